// File: rtl/mem_io_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_io_pkg                                                         |
// | Shared types and constants for the CPU memory / IO bridge:        |
// | bridge state encoding, access-size codes, default IO window base  |
// | and store-side lane helpers.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mem_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_IOW  = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [31:0] DEF_IO_BASE = 32'hFFFF_FC00;

   // Byte enables for a store of the given size at the given byte offset.
   function automatic logic [3:0] store_lanes(input logic [1:0] size,
                                              input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Narrow stores are copied into every lane so any enabled lane sees them.
   function automatic logic [31:0] store_replicate(input logic [1:0]  size,
                                                   input logic [31:0] data);
      logic [31:0] rep;
      case (size)
         SZ_BYTE: rep = {4{data[7:0]}};
         SZ_HALF: rep = {2{data[15:0]}};
         default: rep = data;
      endcase
      return rep;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_align                                                         |
// | Combinational load-data lane extraction and zero/sign extension.  |
// | Ports:                                                             |
// |   word_i    : raw 32-bit word returned by memory or IO channel     |
// |   addr_lo_i : byte offset of the access within the word            |
// |   size_i    : access size code (byte / half / word)                |
// |   signed_i  : sign-extend narrow loads when 1                      |
// |   data_o    : aligned, extended load result                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module load_align
   import mem_io_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      w_half = 16'h0000;
      data_o = word_i;
      case (addr_lo_i)
         2'd0:    w_byte = word_i[7:0];
         2'd1:    w_byte = word_i[15:8];
         2'd2:    w_byte = word_i[23:16];
         default: w_byte = word_i[31:24];
      endcase
      w_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      case (size_i)
         SZ_BYTE: data_o = {{24{signed_i & w_byte[7]}}, w_byte};
         SZ_HALF: data_o = {{16{signed_i & w_half[15]}}, w_half};
         default: data_o = word_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_io_bridge                                                      |
// | Single-outstanding CPU load/store bridge that steers each access  |
// | to a synchronous memory or to one of NUM_CH memory-mapped IO       |
// | channels with a fixed wait-state count.                            |
// | Ports:                                                             |
// |   clk, rst_n            : clock, synchronous active-low reset      |
// |   req_*, addr_in, wdata : CPU request (accepted when req_ready)    |
// |   rsp_valid, rdata,     : one-cycle completion, load data and      |
// |   addr_err                misalign / bad-channel error flag        |
// |   m_*                   : synchronous memory port                  |
// |   io_*                  : IO channel selects, write strobe, data   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_io_bridge
   import mem_io_pkg::*;
#(
   parameter int          NUM_CH         = 4,
   parameter logic [31:0] IO_BASE        = DEF_IO_BASE,
   parameter int          CH_STRIDE_LOG2 = 4,
   parameter int          IO_WAIT        = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           addr_in,
   input  logic [31:0]           wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rdata,
   output logic                  addr_err,
   output logic [31:0]           m_addr,
   output logic                  m_re,
   output logic                  m_we,
   output logic [3:0]            m_be,
   output logic [31:0]           m_wdata,
   input  logic [31:0]           m_rdata,
   output logic [NUM_CH-1:0]     io_sel,
   output logic                  io_we,
   output logic [31:0]           io_wdata,
   input  logic [32*NUM_CH-1:0]  io_rdata
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q, io_word_q, io_word_d;
   logic        write_q, signed_q, err_q, io_q;
   logic [1:0]  size_q;
   logic [2:0]  ch_q;
   logic [3:0]  wait_q, wait_d;

   logic        w_accept, w_is_io, w_err, w_io_last;
   logic [31:0] w_ch_idx, w_io_word, w_load;

   assign w_accept  = req_valid && (state_q == ST_IDLE);
   assign w_is_io   = (addr_in >= IO_BASE);
   assign w_ch_idx  = (addr_in - IO_BASE) >> CH_STRIDE_LOG2;
   assign w_io_last = (state_q == ST_IOW) && (wait_q == 4'd0);

   always_comb begin
      w_err = 1'b0;
      case (req_size)
         SZ_BYTE: w_err = 1'b0;
         SZ_HALF: w_err = addr_in[0];
         SZ_WORD: w_err = (addr_in[1:0] != 2'b00);
         default: w_err = 1'b1;
      endcase
      if (w_is_io && (w_ch_idx >= 32'(NUM_CH))) w_err = 1'b1;
   end

   // Channel mux uses constant part-selects so no out-of-range index is built.
   always_comb begin
      w_io_word = 32'h0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_q == 3'(k)) w_io_word = io_rdata[32*k +: 32];
      end
   end

   // State register and request capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         write_q   <= 1'b0;
         signed_q  <= 1'b0;
         size_q    <= SZ_BYTE;
         err_q     <= 1'b0;
         io_q      <= 1'b0;
         ch_q      <= 3'd0;
         wait_q    <= 4'd0;
         io_word_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         io_word_q <= io_word_d;
         if (w_accept) begin
            addr_q   <= addr_in;
            wdata_q  <= wdata;
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            err_q    <= w_err;
            io_q     <= w_is_io;
            ch_q     <= w_ch_idx[2:0];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      io_word_d = io_word_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err)        state_d = ST_RESP;
               else if (w_is_io) state_d = ST_IOW;
               else              state_d = ST_MEM;
               wait_d = 4'(IO_WAIT - 1);
            end
         end
         ST_MEM: state_d = ST_RESP;
         ST_IOW: begin
            if (w_io_last) begin
               state_d   = ST_RESP;
               io_word_d = w_io_word;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory read data arrives in RESP, one cycle after m_re; IO data was
   // registered in the last wait cycle.
   load_align u_load_align (
      .word_i    (io_q ? io_word_q : m_rdata),
      .addr_lo_i (addr_q[1:0]),
      .size_i    (size_q),
      .signed_i  (signed_q),
      .data_o    (w_load)
   );

   // Output decode.
   always_comb begin
      req_ready = rst_n && (state_q == ST_IDLE);
      rsp_valid = 1'b0;
      rdata     = 32'h0;
      addr_err  = 1'b0;
      m_addr    = 32'h0;
      m_re      = 1'b0;
      m_we      = 1'b0;
      m_be      = 4'h0;
      m_wdata   = 32'h0;
      io_sel    = '0;
      io_we     = 1'b0;
      io_wdata  = 32'h0;
      case (state_q)
         ST_MEM: begin
            m_addr = {addr_q[31:2], 2'b00};
            m_re   = !write_q;
            m_we   = write_q;
            m_be   = store_lanes(size_q, addr_q[1:0]);
            if (write_q) m_wdata = store_replicate(size_q, wdata_q);
         end
         ST_IOW: begin
            for (int k = 0; k < NUM_CH; k++) io_sel[k] = (ch_q == 3'(k));
            io_we = write_q && w_io_last;
            if (write_q) io_wdata = store_replicate(size_q, wdata_q);
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            addr_err  = err_q;
            if (!err_q && !write_q) rdata = w_load;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_io_bridge                                                   |
// | Self-checking bench: directed scenarios plus randomized loads and  |
// | stores against an arithmetic reference model of the bridge.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_io_bridge;

   localparam int          NUM_CH  = 4;
   localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
   localparam int          STRIDE  = 4;
   localparam int          IO_WAIT = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]           req_size = 2'd0;
   logic [31:0]          addr_in = 32'h0, wdata = 32'h0;
   logic                 rsp_valid, addr_err;
   logic [31:0]          rdata;
   logic [31:0]          m_addr, m_wdata;
   logic [31:0]          m_rdata = 32'h0;
   logic                 m_re, m_we, io_we;
   logic [3:0]           m_be;
   logic [NUM_CH-1:0]    io_sel;
   logic [31:0]          io_wdata;
   logic [32*NUM_CH-1:0] io_rdata = '0;

   logic [31:0] mem_word = 32'h0;
   int n_checks = 0;
   int n_errors = 0;

   mem_io_bridge #(
      .NUM_CH(NUM_CH), .IO_BASE(IO_BASE), .CH_STRIDE_LOG2(STRIDE), .IO_WAIT(IO_WAIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .addr_in(addr_in), .wdata(wdata),
      .rsp_valid(rsp_valid), .rdata(rdata), .addr_err(addr_err),
      .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
      .m_rdata(m_rdata),
      .io_sel(io_sel), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data appears one cycle after a read strobe, garbage otherwise.
   always @(posedge clk) m_rdata <= m_re ? mem_word : $urandom;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
      if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
      if (a >= IO_BASE && ((a - IO_BASE) / (1 << STRIDE)) >= NUM_CH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg,
                                              input logic [31:0] a, input logic [31:0] word);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (word >> (8 * (a % 4))) % 256;
         if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (word >> (8 * (a % 4))) % 65536;
         if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 4'(1 << (a % 4));
      if (sz == 2'd1) return 4'(3 << (a % 4));
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_rep(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
      if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   // One complete transaction, starting and ending with the bridge idle.
   task automatic do_txn(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word);
      bit                err, io;
      int                lat, k, ch;
      logic [3:0]        be, obs_be;
      logic [31:0]       rep, exp_rd;
      logic [NUM_CH-1:0] sel_e;
      logic [10:0]       o, e;
      err    = model_err(sz, a);
      io     = (a >= IO_BASE);
      ch     = io ? int'((a - IO_BASE) >> STRIDE) : 0;
      lat    = err ? 1 : (io ? IO_WAIT + 1 : 2);
      be     = model_be(sz, a);
      rep    = model_rep(sz, wd);
      exp_rd = (err || w) ? 32'h0 : model_load(sz, sg, a, word);
      sel_e  = '0;
      if (io && !err) sel_e[ch] = 1'b1;
      mem_word = word;
      for (int c = 0; c < NUM_CH; c++) io_rdata[32*c +: 32] = $urandom;

      addr_in = a; wdata = wd; req_write = w; req_size = sz; req_signed = sg; req_valid = 1'b1;
      check_eq("ready_idle", 32'(req_ready), 32'd1);
      step();
      // Scramble request inputs: the captured copy must be used.
      req_valid = 1'b0; addr_in = $urandom; wdata = $urandom;
      req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      k = 1;
      while (!rsp_valid && k <= 20) begin
         for (int c = 0; c < NUM_CH; c++)
            io_rdata[32*c +: 32] = (c == ch && k == IO_WAIT) ? word : $urandom;
         obs_be = (!io && !w) ? 4'h0 : m_be;
         o = {m_re, m_we, io_we, io_sel, obs_be};
         if (io) e = {1'b0, 1'b0, (w && k == IO_WAIT), sel_e, 4'h0};
         else    e = {(!w && k == 1), (w && k == 1), 1'b0, {NUM_CH{1'b0}}, (w && k == 1) ? be : 4'h0};
         check_eq("strobes", 32'(o), 32'(e));
         check_eq("ready_busy", 32'(req_ready), 32'd0);
         if (!io && k == 1) check_eq("m_addr", m_addr, {a[31:2], 2'b00});
         if (w && !io && k == 1) check_eq("m_wdata", m_wdata, rep);
         if (w && io && k == IO_WAIT) check_eq("io_wdata", io_wdata, rep);
         step();
         k++;
      end
      check_eq("latency", 32'(k), 32'(lat));
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("addr_err", 32'(addr_err), 32'(err));
      check_eq("rdata", rdata, exp_rd);
      check_eq("strobes_resp", 32'({m_re, m_we, io_we, io_sel, m_be}), 32'd0);
      step();
      check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      bit          w, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;

      // Reset state.
      rst_n = 1'b0;
      step(); step();
      check_eq("reset_ctl", 32'({req_ready, rsp_valid, addr_err, m_re, m_we, io_we, io_sel, m_be}), 32'd0);
      check_eq("reset_data", rdata | m_addr | m_wdata | io_wdata, 32'd0);
      rst_n = 1'b1;
      step();
      check_eq("ready_after_reset", 32'(req_ready), 32'd1);

      // Directed scenarios.
      do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
      do_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h8011_2233);
      do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h8011_2233);
      do_txn(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0);
      do_txn(1'b0, 2'd2, 1'b0, 32'hFFFF_FC10, 32'h0, 32'h0000_5A5A);
      do_txn(1'b1, 2'd2, 1'b0, 32'hFFFF_FC10, 32'hCAFE_F00D, 32'h0);
      do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111);
      do_txn(1'b0, 2'd2, 1'b0, 32'hFFFF_FC40, 32'h0, 32'h2222_2222);
      do_txn(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0, 32'h3333_3333);
      do_txn(1'b0, 2'd1, 1'b1, 32'hFFFF_FC32, 32'h0, 32'h9ABC_1234);

      // Reset in the middle of an IO wait.
      addr_in = 32'hFFFF_FC10; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      check_eq("io_sel_inflight", 32'(io_sel), 32'h2);
      rst_n = 1'b0;
      step();
      check_eq("io_sel_after_rst", 32'(io_sel), 32'd0);
      check_eq("rsp_after_rst", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      step();
      check_eq("ready_after_rst", 32'(req_ready), 32'd1);
      check_eq("no_rsp_idle", 32'(rsp_valid), 32'd0);
      do_txn(1'b0, 2'd0, 1'b1, 32'hFFFF_FC21, 32'h0, 32'h0000_F700);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom);
         sg = 1'($urandom);
         sz = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0) sz = 2'd3;
         r = $urandom_range(0, 3);
         if (r < 2)       a = $urandom & 32'h0000_FFFF;
         else if (r == 2) a = IO_BASE + $urandom_range(0, 127);
         else             a = IO_BASE + $urandom_range(0, 1023);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         do_txn(w, sz, sg, a, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
